// File: rtl/addsub_pkg.sv
// Shared definitions for the add/subtract sequencer.
//  - state_e        : sequencer states
//  - MODE_ADD/SUB   : operation select values, as seen on sw_mode and add_cin
//  - BCD_ADJ_*      : double-dabble correction threshold and offset
//  - bcd_adjust()   : one double-dabble nibble correction step
package addsub_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_LATCH  = 3'd3,
    ST_CONV   = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  // A nibble of 5 or more would reach 10+ after the next shift, so bump it
  // by 3 now; the shift then carries the overflow into the next digit.
  function automatic logic [3:0] bcd_adjust(input logic [3:0] nib);
    return (nib >= BCD_ADJ_THRESH) ? nib + BCD_ADJ_ADD : nib;
  endfunction

endpackage

// File: rtl/key_pulse.sv
// Push-button conditioner: two-flop synchroniser followed by a falling-edge
// detector. A press (high -> low) gives exactly one single-cycle pulse no
// matter how long the button is held.
// Ports:
//  clk_i    in  system clock
//  rst_i    in  asynchronous reset, active-high
//  key_n_i  in  raw active-low button, asynchronous to clk_i
//  pulse_o  out one-cycle pulse on each press
module key_pulse (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic pulse_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // NOTE: key_n_i is asynchronous; only sync2_q (two flops deep) may feed
  // logic, sync1_q is allowed to go metastable.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // prev_q resets low, so the first rise of the idle-high button after reset
  // cannot be mistaken for a press.
  assign pulse_o = prev_q & ~sync2_q;

endmodule

// File: rtl/addsub_seq_ctrl.sv
// Sequencer for the external ripple add/subtract datapath and the BCD
// display path. Two key presses capture operands A and B from sw_data, a go
// press drives the adder, samples sum/carry, converts the magnitude to BCD
// serially and holds sign + digits for the 7-segment decoders.
// Ports:
//  CLOCK_50            in  system clock
//  rst                 in  asynchronous reset, active-high
//  key_load_n/key_go_n in  raw active-low buttons
//  sw_data, sw_mode    in  operand value, 0 = add / 1 = subtract (A - B)
//  add_x/add_y/add_cin out adder operands and carry-in
//  add_sum/add_cout    in  adder result
//  result, neg         out magnitude and sign of the last result
//  ones/tens/hundreds  out BCD digits of result
//  a_valid/b_valid     out operand captured flags
//  busy, done          out operation in flight / one-cycle completion pulse
import addsub_pkg::*;

module addsub_seq_ctrl #(
  parameter int WIDTH      = 4,
  parameter int SETTLE_CYC = 1
) (
  input  logic             CLOCK_50,
  input  logic             rst,
  input  logic             key_load_n,
  input  logic             key_go_n,
  input  logic [WIDTH-1:0] sw_data,
  input  logic             sw_mode,
  output logic [WIDTH-1:0] add_x,
  output logic [WIDTH-1:0] add_y,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic [WIDTH:0]   result,
  output logic             neg,
  output logic [3:0]       ones,
  output logic [3:0]       tens,
  output logic [1:0]       hundreds,
  output logic             a_valid,
  output logic             b_valid,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [3:0] CONV_LAST   = 4'(WIDTH);

  logic load_p;
  logic go_p;

  key_pulse u_key_load (
    .clk_i   (CLOCK_50),
    .rst_i   (rst),
    .key_n_i (key_load_n),
    .pulse_o (load_p)
  );

  key_pulse u_key_go (
    .clk_i   (CLOCK_50),
    .rst_i   (rst),
    .key_n_i (key_go_n),
    .pulse_o (go_p)
  );

  state_e           state_q;
  logic             ptr_q;          // 0 = next load goes to A, 1 = to B
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic             mode_q;
  logic [3:0]       settle_cnt_q;
  logic [3:0]       conv_cnt_q;
  logic [WIDTH:0]   shift_q;        // binary bits still to be shifted in
  logic [8:0]       bcd_q;          // scratch: {hundreds[0], tens, ones}

  logic [WIDTH-1:0] add_x_q;
  logic [WIDTH-1:0] add_y_q;
  logic             add_cin_q;
  logic [WIDTH:0]   result_q;
  logic             neg_q;
  logic [3:0]       ones_q;
  logic [3:0]       tens_q;
  logic [1:0]       hundreds_q;
  logic             a_valid_q;
  logic             b_valid_q;
  logic             busy_q;
  logic             done_q;

  // Result interpretation at LATCH. For subtract the adder computed
  // A + ~B + 1; no carry-out means A < B and the sum is the negative
  // difference in two's complement.
  logic [WIDTH-1:0] sum_neg_d;
  logic [WIDTH:0]   latch_res_d;
  logic             latch_neg_d;

  assign sum_neg_d = ~add_sum + {{(WIDTH-1){1'b0}}, 1'b1};

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    latch_res_d = {add_cout, add_sum};
    latch_neg_d = 1'b0;
    if (mode_q == MODE_SUB) begin
      if (add_cout) begin
        latch_res_d = {1'b0, add_sum};
      end else begin
        latch_res_d = {1'b0, sum_neg_d};
        latch_neg_d = 1'b1;
      end
    end
  end

  // One double-dabble step: correct the digits, then shift in the next
  // binary bit MSB first. The hundreds digit never exceeds 2 for legal
  // WIDTH, so it needs no correction and only its low bit is kept in the
  // scratch; its high bit appears only in the final shift.
  logic [8:0] bcd_adj_d;
  logic [9:0] bcd_shift_d;

  assign bcd_adj_d   = {bcd_q[8], bcd_adjust(bcd_q[7:4]), bcd_adjust(bcd_q[3:0])};
  assign bcd_shift_d = {bcd_adj_d, shift_q[WIDTH]};

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      mode_q       <= MODE_ADD;
      settle_cnt_q <= '0;
      conv_cnt_q   <= '0;
      shift_q      <= '0;
      bcd_q        <= '0;
      add_x_q      <= '0;
      add_y_q      <= '0;
      add_cin_q    <= 1'b0;
      result_q     <= '0;
      neg_q        <= 1'b0;
      ones_q       <= '0;
      tens_q       <= '0;
      hundreds_q   <= '0;
      a_valid_q    <= 1'b0;
      b_valid_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // A load in the same cycle as go takes priority; go is dropped.
          if (load_p) begin
            if (!ptr_q) begin
              op_a_q    <= sw_data;
              a_valid_q <= 1'b1;
              b_valid_q <= 1'b0;
              ptr_q     <= 1'b1;
            end else begin
              op_b_q    <= sw_data;
              b_valid_q <= 1'b1;
              ptr_q     <= 1'b0;
            end
          end else if (go_p && a_valid_q && b_valid_q) begin
            mode_q  <= sw_mode;
            busy_q  <= 1'b1;
            state_q <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          add_x_q      <= op_a_q;
          add_y_q      <= (mode_q == MODE_SUB) ? ~op_b_q : op_b_q;
          add_cin_q    <= mode_q;
          settle_cnt_q <= '0;
          state_q      <= ST_SETTLE;
        end

        ST_SETTLE: begin
          if (settle_cnt_q == SETTLE_LAST) begin
            state_q <= ST_LATCH;
          end else begin
            settle_cnt_q <= settle_cnt_q + 4'd1;
          end
        end

        ST_LATCH: begin
          result_q   <= latch_res_d;
          neg_q      <= latch_neg_d;
          shift_q    <= latch_res_d;
          bcd_q      <= '0;
          conv_cnt_q <= '0;
          state_q    <= ST_CONV;
        end

        ST_CONV: begin
          bcd_q   <= bcd_shift_d[8:0];
          shift_q <= {shift_q[WIDTH-1:0], 1'b0};
          if (conv_cnt_q == CONV_LAST) begin
            // Digits become visible together with the done pulse.
            ones_q     <= bcd_shift_d[3:0];
            tens_q     <= bcd_shift_d[7:4];
            hundreds_q <= bcd_shift_d[9:8];
            done_q     <= 1'b1;
            state_q    <= ST_DONE;
          end else begin
            conv_cnt_q <= conv_cnt_q + 4'd1;
          end
        end

        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign add_x    = add_x_q;
  assign add_y    = add_y_q;
  assign add_cin  = add_cin_q;
  assign result   = result_q;
  assign neg      = neg_q;
  assign ones     = ones_q;
  assign tens     = tens_q;
  assign hundreds = hundreds_q;
  assign a_valid  = a_valid_q;
  assign b_valid  = b_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Testbench for addsub_seq_ctrl: models the external adder, drives button
// presses, and checks every done pulse against an arithmetic reference
// model through a scoreboard queue.
module tb_addsub_seq_ctrl;

  localparam int W   = 4;
  localparam int S   = 1;
  localparam int LAT = S + W + 4;   // go pulse cycle -> done cycle

  logic         CLOCK_50 = 1'b0;
  logic         rst = 1'b1;
  logic         key_load_n = 1'b1;
  logic         key_go_n = 1'b1;
  logic [W-1:0] sw_data = '0;
  logic         sw_mode = 1'b0;
  logic [W-1:0] add_x;
  logic [W-1:0] add_y;
  logic         add_cin;
  logic [W-1:0] add_sum;
  logic         add_cout;
  logic [W:0]   result;
  logic         neg;
  logic [3:0]   ones;
  logic [3:0]   tens;
  logic [1:0]   hundreds;
  logic         a_valid;
  logic         b_valid;
  logic         busy;
  logic         done;

  addsub_seq_ctrl #(.WIDTH(W), .SETTLE_CYC(S)) dut (
    .CLOCK_50   (CLOCK_50),
    .rst        (rst),
    .key_load_n (key_load_n),
    .key_go_n   (key_go_n),
    .sw_data    (sw_data),
    .sw_mode    (sw_mode),
    .add_x      (add_x),
    .add_y      (add_y),
    .add_cin    (add_cin),
    .add_sum    (add_sum),
    .add_cout   (add_cout),
    .result     (result),
    .neg        (neg),
    .ones       (ones),
    .tens       (tens),
    .hundreds   (hundreds),
    .a_valid    (a_valid),
    .b_valid    (b_valid),
    .busy       (busy),
    .done       (done)
  );

  // External ripple adder stand-in.
  assign {add_cout, add_sum} = {1'b0, add_x} + {1'b0, add_y} + {{W{1'b0}}, add_cin};

  always #10 CLOCK_50 = ~CLOCK_50;

  int unsigned cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  typedef struct {
    int           result;
    bit           neg;
    int           ones;
    int           tens;
    int           hundreds;
    logic [W-1:0] x;
    logic [W-1:0] y;
    bit           cin;
    int unsigned  cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model of the operand registers.
  logic [W-1:0] ma = '0;
  logic [W-1:0] mb = '0;
  bit           mav = 0;
  bit           mbv = 0;
  bit           mptr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge CLOCK_50) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("latency",  cyc,              e.cyc);
        check("result",   32'(result),      32'(e.result));
        check("neg",      32'(neg),         32'(e.neg));
        check("ones",     32'(ones),        32'(e.ones));
        check("tens",     32'(tens),        32'(e.tens));
        check("hundreds", 32'(hundreds),    32'(e.hundreds));
        check("add_x",    32'(add_x),       32'(e.x));
        check("add_y",    32'(add_y),       32'(e.y));
        check("add_cin",  32'(add_cin),     32'(e.cin));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic model_load(input logic [W-1:0] v);
    if (!mptr) begin
      ma = v; mav = 1; mbv = 0; mptr = 1;
    end else begin
      mb = v; mbv = 1; mptr = 0;
    end
  endtask

  function automatic exp_t model_op(input bit mode, input int unsigned due);
    exp_t e;
    int   a;
    int   b;
    a = int'(ma);
    b = int'(mb);
    e.neg = 0;
    if (!mode)        e.result = a + b;
    else if (a >= b)  e.result = a - b;
    else begin
      e.result = b - a;
      e.neg    = 1;
    end
    e.ones     = e.result % 10;
    e.tens     = (e.result / 10) % 10;
    e.hundreds = e.result / 100;
    e.x        = ma;
    e.y        = mode ? ~mb : mb;
    e.cin      = mode;
    e.cyc      = due;
    return e;
  endfunction

  // Each task starts and ends just after a falling edge with the DUT idle.
  task automatic press_load(input logic [W-1:0] v);
    sw_data    = v;
    key_load_n = 1'b0;
    tick(3);
    key_load_n = 1'b1;
    model_load(v);
    tick(2);
  endtask

  // The go pulse reaches the FSM two edges after the press.
  task automatic press_go(input bit mode, input bit expect_run);
    sw_mode  = mode;
    key_go_n = 1'b0;
    if (expect_run && mav && mbv) sb.push_back(model_op(mode, cyc + 2 + LAT));
    tick(3);
    key_go_n = 1'b1;
    sw_mode  = 1'($urandom_range(1));
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((sb.size() != 0 || busy) && k < 200) begin
      tick(1);
      k++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
    tick(2);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_result"},  32'(result),   32'd0);
    check({tag, "_neg"},     32'(neg),      32'd0);
    check({tag, "_digits"},  32'({hundreds, tens, ones}), 32'd0);
    check({tag, "_adder"},   32'({add_x, add_y, add_cin}), 32'd0);
    check({tag, "_valid"},   32'({a_valid, b_valid}), 32'd0);
    check({tag, "_busy"},    32'(busy),     32'd0);
    check({tag, "_done"},    32'(done),     32'd0);
  endtask

  initial begin
    int unsigned c;

    tick(3);
    check_all_zero("reset");
    rst = 1'b0;
    tick(3);

    // Directed cases.
    press_load(4'd5);  press_load(4'd3);  press_go(0, 1); wait_drain();
    press_load(4'd9);  press_load(4'd9);  press_go(0, 1); wait_drain();
    press_load(4'd3);  press_load(4'd5);  press_go(1, 1); wait_drain();
    check("sub_hold_add_y",   32'(add_y),   32'hA);
    check("sub_hold_add_cin", 32'(add_cin), 32'd1);
    press_load(4'd15); press_load(4'd15); press_go(0, 1); wait_drain();
    press_go(1, 1); wait_drain();

    // Go with only A loaded is ignored.
    press_load(4'd7);
    press_go(0, 1);
    tick(LAT + 4);
    check("go_no_b_busy", 32'(busy), 32'd0);
    check("go_no_b_valid", 32'({a_valid, b_valid}), 32'b10);
    press_load(4'd2);

    // Presses during the conversion are discarded; operands stay 7 and 2.
    c = cyc;
    press_go(0, 1);                  // returns at c + 3
    tick(1);                         // c + 4: pulses land at c + 6, in CONV
    sw_data    = 4'd11;
    sw_mode    = 1'b1;
    key_load_n = 1'b0;
    key_go_n   = 1'b0;
    tick(3);
    key_load_n = 1'b1;
    key_go_n   = 1'b1;
    check("busy_press_window", cyc - c, 32'd7);
    wait_drain();
    check("after_busy_valid", 32'({a_valid, b_valid}), 32'b11);
    press_go(1, 1); wait_drain();    // rerun: 7 - 2 = 5

    // Load and go in the same cycle: load wins, go dropped.
    press_load(4'd4);
    sw_data    = 4'd6;
    sw_mode    = 1'b0;
    key_load_n = 1'b0;
    key_go_n   = 1'b0;
    tick(3);
    key_load_n = 1'b1;
    key_go_n   = 1'b1;
    model_load(4'd6);
    tick(LAT + 4);
    check("load_wins_busy", 32'(busy), 32'd0);
    check("load_wins_valid", 32'({a_valid, b_valid}), 32'b11);
    press_go(0, 1); wait_drain();    // 4 + 6 = 10

    // Reset in the middle of the conversion aborts without a done pulse.
    press_load(4'd13); press_load(4'd6);
    c = cyc;
    press_go(0, 0);
    tick(int'(c + 7 - cyc));
    check("abort_in_conv_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick(1);
    check_all_zero("abort");
    mav = 0; mbv = 0; mptr = 0;
    tick(LAT);
    rst = 1'b0;
    tick(3);
    press_load(4'd12); press_load(4'd7); press_go(1, 1); wait_drain();

    // Randomised operations.
    for (int i = 0; i < 40; i++) begin
      press_load(W'($urandom_range((1 << W) - 1)));
      press_load(W'($urandom_range((1 << W) - 1)));
      press_go(1'($urandom_range(1)), 1);
      wait_drain();
    end

    tick(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
